// File: rtl/mer_meas_sequencer.sv
// mer_meas_sequencer
//   Sequences one windowed MER / error-power measurement on the 16-QAM symbol
//   path: clear accumulators, let the channel pipeline flush, align to the
//   LFSR sync pulse, accumulate 2^WIN_LOG2 symbols, then strobe a result latch.
//
// Ports
//   clk          system clock (sys_clk)
//   reset        asynchronous active-low reset
//   clk_en       symbol enable, one clk wide
//   start        measurement request (level or pulse)
//   abort        synchronous abort, beats start
//   sync_pulse   LFSR cycle marker, qualified by clk_en
//   acc_clr      accumulator clear, one clk
//   acc_en       accumulator enable (combinational, only on clk_en in ACCUM)
//   latch        result latch strobe, one clk
//   busy         high in SETTLE / WAIT_SYNC / ACCUM / LATCH
//   done         measurement finished, held until next start or abort
//   timeout_err  no sync found; meaningful while done=1
//   sym_count    symbols accumulated in the current window
//   state        FSM state code for debug
//
// state     | meaning
// IDLE  (0) | waiting for start
// SETTLE(1) | counting pipeline-flush symbols after the clear
// WAIT  (2) | searching for sync, timeout running
// ACCUM (3) | window open, acc_en on every symbol
// LATCH (4) | one-clk result latch strobe
// DONE  (5) | result (or timeout) available
module mer_meas_sequencer #(
  parameter int WIN_LOG2     = 18,
  parameter int SETTLE_SYMS  = 32,
  parameter int TIMEOUT_SYMS = 4194304
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_en,
  input  logic                start,
  input  logic                abort,
  input  logic                sync_pulse,
  output logic                acc_clr,
  output logic                acc_en,
  output logic                latch,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [WIN_LOG2-1:0] sym_count,
  output logic [2:0]          state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_ACCUM  = 3'd3;
  localparam logic [2:0] S_LATCH  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [7:0]          SETTLE_LOAD  = 8'(SETTLE_SYMS);
  localparam logic [22:0]         TIMEOUT_LOAD = 23'(TIMEOUT_SYMS);
  localparam logic [WIN_LOG2-1:0] SYM_LAST     = '1;
  localparam logic [WIN_LOG2-1:0] SYM_ONE      = WIN_LOG2'(1);

  logic [2:0]          state_q, state_d;
  logic [7:0]          settle_cnt_q, settle_cnt_d;
  logic [22:0]         tmo_cnt_q, tmo_cnt_d;
  logic [WIN_LOG2-1:0] sym_count_q, sym_count_d;
  logic                acc_clr_q, acc_clr_d;
  logic                latch_q, latch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                terr_q, terr_d;

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      sym_count_q  <= '0;
      acc_clr_q    <= 1'b0;
      latch_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      sym_count_q  <= sym_count_d;
      acc_clr_q    <= acc_clr_d;
      latch_q      <= latch_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      terr_q       <= terr_d;
    end
  end

  // next state; the settle and timeout timers are down-counters that fire
  // on the enable that brings them from 1 to 0
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
        S_SETTLE:       if (clk_en && settle_cnt_q == 8'd1) state_d = S_WAIT;
        S_WAIT: begin
          if (clk_en) begin
            if (sync_pulse)                 state_d = S_ACCUM;
            else if (tmo_cnt_q == 23'd1)    state_d = S_DONE;
          end
        end
        S_ACCUM:        if (clk_en && sym_count_q == SYM_LAST) state_d = S_LATCH;
        S_LATCH:        state_d = S_DONE;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // counters and registered outputs, derived from the transition being taken
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    sym_count_d  = sym_count_q;
    if (!abort) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            settle_cnt_d = SETTLE_LOAD;
            tmo_cnt_d    = TIMEOUT_LOAD;
            sym_count_d  = '0;
          end
        end
        S_SETTLE: if (clk_en) settle_cnt_d = settle_cnt_q - 8'd1;
        S_WAIT:   if (clk_en && !sync_pulse) tmo_cnt_d = tmo_cnt_q - 23'd1;
        S_ACCUM:  if (clk_en) sym_count_d = sym_count_q + SYM_ONE;
        default: ;
      endcase
    end

    acc_clr_d = (state_q == S_IDLE || state_q == S_DONE) && (state_d == S_SETTLE);
    latch_d   = (state_d == S_LATCH);
    busy_d    = (state_d == S_SETTLE) || (state_d == S_WAIT) ||
                (state_d == S_ACCUM)  || (state_d == S_LATCH);
    done_d    = (state_d == S_DONE);
    // timeout_err is set only by the WAIT->DONE exit and survives while DONE holds
    terr_d    = (state_d == S_DONE) &&
                ((state_q == S_WAIT) || (state_q == S_DONE && terr_q));
  end

  assign acc_en      = (state_q == S_ACCUM) && clk_en;
  assign acc_clr     = acc_clr_q;
  assign latch       = latch_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign sym_count   = sym_count_q;
  assign state       = state_q;

endmodule
